// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants and types for the ID-stage branch resolution controller.
//   - CMP_* : compare opcodes handed to the branch comparator
//   - FWD_* : comparator operand source selects
//   - state_e : resolution FSM states
//   - stage_t : destination-register view of one downstream pipeline stage
package branch_resolve_ctrl_pkg;

  localparam logic [1:0] CMP_BEQ  = 2'd0;
  localparam logic [1:0] CMP_BNE  = 2'd1;
  localparam logic [1:0] CMP_BLEZ = 2'd2;
  localparam logic [1:0] CMP_BGTZ = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Compare operands: 0 = rs (CMPA), 1 = rt (CMPB)
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_RESOLVED = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] wa;
    logic       regwrite;
    logic       is_load;
  } stage_t;

  // A load always produces a register result, so is_load alone counts as a write.
  function automatic logic writes(stage_t s, logic [4:0] r);
    return (s.regwrite || s.is_load) && (s.wa == r);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-facing signal bundle of branch_resolve_ctrl.
//   slave  : controller side (ID/EX/MEM/WB status + comparator result in,
//            comparator controls and pipeline stall/redirect/flush out)
//   master : pipeline/bench side
interface branch_resolve_ctrl_if;
  logic       id_valid;
  logic       id_is_branch;
  logic [1:0] id_cmp_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_wa;
  logic       ex_regwrite;
  logic       ex_is_load;
  logic [4:0] mem_wa;
  logic       mem_regwrite;
  logic       mem_is_load;
  logic [4:0] wb_wa;
  logic       wb_regwrite;
  logic       cmp_out;
  logic [1:0] cmp_op;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic       redirect;
  logic       flush_if;

  modport slave (
    input  id_valid, id_is_branch, id_cmp_op, id_rs, id_rt,
           ex_wa, ex_regwrite, ex_is_load, mem_wa, mem_regwrite, mem_is_load,
           wb_wa, wb_regwrite, cmp_out,
    output cmp_op, fwd_a_sel, fwd_b_sel, stall, redirect, flush_if
  );

  modport master (
    output id_valid, id_is_branch, id_cmp_op, id_rs, id_rt,
           ex_wa, ex_regwrite, ex_is_load, mem_wa, mem_regwrite, mem_is_load,
           wb_wa, wb_regwrite, cmp_out,
    input  cmp_op, fwd_a_sel, fwd_b_sel, stall, redirect, flush_if
  );
endinterface

// File: rtl/branch_resolve_ctrl_hazard.sv
// branch_hazard_detect: combinational operand hazard check for the branch in ID.
//   br_in_id       : a valid branch sits in ID
//   src[NUM_OPS]   : compare operand registers (0 = rs, 1 = rt)
//   ex_s, mem_s    : EX / MEM destination info
//   wb_wa/regwrite : WB destination info
//   fwd_sel        : per-operand comparator source (FWD_*)
//   ready          : no operand is waiting on an in-flight result
module branch_hazard_detect
  import branch_resolve_ctrl_pkg::*;
(
  input  logic                       br_in_id,
  input  logic [NUM_OPS-1:0][4:0]    src,
  input  stage_t                     ex_s,
  input  stage_t                     mem_s,
  input  logic [4:0]                 wb_wa,
  input  logic                       wb_regwrite,
  output logic [NUM_OPS-1:0][1:0]    fwd_sel,
  output logic                       ready
);
  logic [NUM_OPS-1:0] hazard;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic live, mem_fwd, wb_fwd;
    assign live = br_in_id && (src[g] != 5'd0);
    // EX results are not available to ID yet; MEM load data arrives only in WB.
    assign hazard[g] = live && (writes(ex_s, src[g]) ||
                                (mem_s.is_load && writes(mem_s, src[g])));
    assign mem_fwd = !mem_s.is_load && writes(mem_s, src[g]);
    assign wb_fwd  = wb_regwrite && (wb_wa == src[g]);
    // MEM holds the younger value, so it wins over WB.
    assign fwd_sel[g] = (!live || hazard[g]) ? FWD_RF  :
                        mem_fwd              ? FWD_MEM :
                        wb_fwd               ? FWD_WB  : FWD_RF;
  end

  assign ready = ~|hazard;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences ID-stage branch resolution around the comparator.
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : pipeline status in; cmp_op/fwd selects/stall/redirect/flush_if out
//   busy           : FSM not idle
//   err_watchdog   : sticky, a branch re-checked in WAIT more than MAX_STALL times
//   cnt_branch/cnt_taken/cnt_stall : saturating statistics
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_STALL  = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus,
  output logic                 busy,
  output logic                 err_watchdog,
  output logic [CNT_W-1:0]     cnt_branch,
  output logic [CNT_W-1:0]     cnt_taken,
  output logic [CNT_W-1:0]     cnt_stall
);
  localparam int             SW        = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0]  STALL_SAT = SW'(MAX_STALL + 1);

  state_e                    state_q, state_d;
  logic [SW-1:0]             stall_cnt_q, stall_cnt_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0]          cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0]          cnt_stall_q, cnt_stall_d;
  logic                      br_in_id, ready, resolve, stall;
  logic [NUM_OPS-1:0][1:0]   fwd_sel;
  stage_t                    ex_s, mem_s;

  // Gating id_valid with reset keeps every combinational output quiet while reset is held.
  assign br_in_id = bus.id_valid && !reset && bus.id_is_branch;
  assign ex_s  = '{wa: bus.ex_wa,  regwrite: bus.ex_regwrite,  is_load: bus.ex_is_load};
  assign mem_s = '{wa: bus.mem_wa, regwrite: bus.mem_regwrite, is_load: bus.mem_is_load};

  branch_hazard_detect u_hzd (
    .br_in_id    (br_in_id),
    .src         ({bus.id_rt, bus.id_rs}),
    .ex_s        (ex_s),
    .mem_s       (mem_s),
    .wb_wa       (bus.wb_wa),
    .wb_regwrite (bus.wb_regwrite),
    .fwd_sel     (fwd_sel),
    .ready       (ready)
  );

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    err_d        = err_q;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    cnt_stall_d  = cnt_stall_q;
    resolve      = 1'b0;
    stall        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!br_in_id) begin
          // Nothing to resolve, or the waiting branch was flushed out of ID.
          state_d = ST_IDLE;
        end else if (ready) begin
          resolve = 1'b1;
          state_d = ST_RESOLVED;
        end else begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          if (state_q == ST_IDLE) begin
            stall_cnt_d = '0;
          end else begin
            // Watchdog counts re-check cycles in WAIT; it flags but never aborts.
            if (stall_cnt_q != STALL_SAT) stall_cnt_d = stall_cnt_q + 1'b1;
            if (stall_cnt_q >= SW'(MAX_STALL)) err_d = 1'b1;
          end
        end
      end
      // One dead cycle so the just-resolved branch leaves ID before re-evaluation.
      ST_RESOLVED: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (resolve && !(&cnt_branch_q))                 cnt_branch_d = cnt_branch_q + 1'b1;
    if (resolve && bus.cmp_out && !(&cnt_taken_q))   cnt_taken_d  = cnt_taken_q + 1'b1;
    if (stall && !(&cnt_stall_q))                    cnt_stall_d  = cnt_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stall_cnt_q  <= '0;
      err_q        <= 1'b0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      err_q        <= err_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign bus.cmp_op    = br_in_id ? bus.id_cmp_op : CMP_BEQ;
  assign bus.fwd_a_sel = fwd_sel[0];
  assign bus.fwd_b_sel = fwd_sel[1];
  assign bus.stall     = stall;
  assign bus.redirect  = resolve && bus.cmp_out;
  assign bus.flush_if  = resolve && bus.cmp_out && (DELAY_SLOT == 0);
  assign busy          = (state_q != ST_IDLE) && !reset;
  assign err_watchdog  = err_q;
  assign cnt_branch    = cnt_branch_q;
  assign cnt_taken     = cnt_taken_q;
  assign cnt_stall     = cnt_stall_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus kept as plain ints; apply() drives them onto both DUT buses.
  int rst, iv, ib, op, rs, rt, exw, exr, exl, mw, mr, ml, ww, wr, cmp;
  logic reset_s;

  branch_resolve_ctrl_if bus_a();
  branch_resolve_ctrl_if bus_b();

  logic        busy_a, err_a, busy_b, err_b;
  logic [15:0] cb_a, ct_a, cs_a;
  logic [3:0]  cb_b, ct_b, cs_b;

  // A: default build. B: tiny counters, tight watchdog, no delay slot.
  branch_resolve_ctrl u_dut_a (
    .clk(clk), .reset(reset_s), .bus(bus_a), .busy(busy_a), .err_watchdog(err_a),
    .cnt_branch(cb_a), .cnt_taken(ct_a), .cnt_stall(cs_a));
  branch_resolve_ctrl #(.CNT_W(4), .MAX_STALL(1), .DELAY_SLOT(0)) u_dut_b (
    .clk(clk), .reset(reset_s), .bus(bus_b), .busy(busy_b), .err_watchdog(err_b),
    .cnt_branch(cb_b), .cnt_taken(ct_b), .cnt_stall(cs_b));

  typedef struct { int cmp_op, fa, fb, stall, redirect, flush, busy, err, cb, ct, cs; } exp_t;
  // st: 0 free, 1 branch held waiting, 2 branch just resolved; w: re-check cycles spent waiting
  typedef struct { int st, w, err, cb, ct, cs; } mst_t;

  exp_t qa[$], qb[$];
  mst_t ma, mb;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic apply();
    reset_s = (rst != 0);
    bus_a.id_valid = (iv != 0);    bus_b.id_valid = (iv != 0);
    bus_a.id_is_branch = (ib != 0); bus_b.id_is_branch = (ib != 0);
    bus_a.id_cmp_op = 2'(op);      bus_b.id_cmp_op = 2'(op);
    bus_a.id_rs = 5'(rs);          bus_b.id_rs = 5'(rs);
    bus_a.id_rt = 5'(rt);          bus_b.id_rt = 5'(rt);
    bus_a.ex_wa = 5'(exw);         bus_b.ex_wa = 5'(exw);
    bus_a.ex_regwrite = (exr != 0); bus_b.ex_regwrite = (exr != 0);
    bus_a.ex_is_load = (exl != 0); bus_b.ex_is_load = (exl != 0);
    bus_a.mem_wa = 5'(mw);         bus_b.mem_wa = 5'(mw);
    bus_a.mem_regwrite = (mr != 0); bus_b.mem_regwrite = (mr != 0);
    bus_a.mem_is_load = (ml != 0); bus_b.mem_is_load = (ml != 0);
    bus_a.wb_wa = 5'(ww);          bus_b.wb_wa = 5'(ww);
    bus_a.wb_regwrite = (wr != 0); bus_b.wb_regwrite = (wr != 0);
    bus_a.cmp_out = (cmp != 0);    bus_b.cmp_out = (cmp != 0);
  endtask

  // Reference: an operand is blocked while its producer is in EX or is a load in MEM;
  // otherwise it comes from the youngest of MEM (non-load) or WB. A branch either
  // resolves this cycle or stalls; the cycle after a resolve never acts.
  task automatic model_step(inout mst_t m, input int max_stall, input int ds,
                            input int cw, output exp_t e);
    int maxc, br, rdy, res, stl, live;
    int r[2], hz[2], sel[2];
    maxc = (1 << cw) - 1;
    br = (rst == 0 && iv != 0 && ib != 0) ? 1 : 0;
    r[0] = rs; r[1] = rt;
    for (int k = 0; k < 2; k++) begin
      live  = (br != 0 && r[k] != 0) ? 1 : 0;
      hz[k] = (live != 0 && (((exr != 0 || exl != 0) && exw == r[k]) ||
                             (ml != 0 && mw == r[k]))) ? 1 : 0;
      if (live == 0 || hz[k] != 0)               sel[k] = 0;
      else if (mr != 0 && ml == 0 && mw == r[k]) sel[k] = 1;
      else if (wr != 0 && ww == r[k])            sel[k] = 2;
      else                                       sel[k] = 0;
    end
    rdy = (hz[0] == 0 && hz[1] == 0) ? 1 : 0;
    res = (br != 0 && m.st != 2 && rdy != 0) ? 1 : 0;
    stl = (br != 0 && m.st != 2 && rdy == 0) ? 1 : 0;
    e.cmp_op   = (br != 0) ? op : 0;
    e.fa       = sel[0];
    e.fb       = sel[1];
    e.stall    = stl;
    e.redirect = (res != 0 && cmp != 0) ? 1 : 0;
    e.flush    = (e.redirect != 0 && ds == 0) ? 1 : 0;
    e.busy     = (rst == 0 && m.st != 0) ? 1 : 0;
    e.err = m.err; e.cb = m.cb; e.ct = m.ct; e.cs = m.cs;
    if (rst != 0) begin
      m = '{default: 0};
    end else begin
      if (res != 0 && m.cb < maxc) m.cb++;
      if (res != 0 && cmp != 0 && m.ct < maxc) m.ct++;
      if (stl != 0 && m.cs < maxc) m.cs++;
      if (stl != 0) begin
        if (m.st == 1) begin
          m.w++;
          if (m.w > max_stall) m.err = 1;
        end else m.w = 0;
      end
      m.st = (res != 0) ? 2 : (stl != 0) ? 1 : 0;
    end
  endtask

  task automatic cycle();
    exp_t e;
    apply();
    model_step(ma, 4, 1, 16, e); qa.push_back(e);
    model_step(mb, 1, 0, 4, e);  qb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    cycle(); tick();
  endtask

  task automatic clr();
    iv = 0; ib = 0; op = 0; rs = 0; rt = 0; exw = 0; exr = 0; exl = 0;
    mw = 0; mr = 0; ml = 0; ww = 0; wr = 0; cmp = 0;
  endtask

  task automatic set_br(input int o, input int a, input int b, input int c);
    iv = 1; ib = 1; op = o; rs = a; rt = b; cmp = c;
  endtask

  function automatic int pct(input int p);
    return ($urandom_range(0, 99) < p) ? 1 : 0;
  endfunction

  task automatic cmp_a(input exp_t e);
    chk("A.cmp_op", 32'(bus_a.cmp_op), e.cmp_op);
    chk("A.fwd_a", 32'(bus_a.fwd_a_sel), e.fa);
    chk("A.fwd_b", 32'(bus_a.fwd_b_sel), e.fb);
    chk("A.stall", 32'(bus_a.stall), e.stall);
    chk("A.redirect", 32'(bus_a.redirect), e.redirect);
    chk("A.flush_if", 32'(bus_a.flush_if), e.flush);
    chk("A.busy", 32'(busy_a), e.busy);
    chk("A.err", 32'(err_a), e.err);
    chk("A.cnt_branch", 32'(cb_a), e.cb);
    chk("A.cnt_taken", 32'(ct_a), e.ct);
    chk("A.cnt_stall", 32'(cs_a), e.cs);
  endtask

  task automatic cmp_b(input exp_t e);
    chk("B.cmp_op", 32'(bus_b.cmp_op), e.cmp_op);
    chk("B.fwd_a", 32'(bus_b.fwd_a_sel), e.fa);
    chk("B.fwd_b", 32'(bus_b.fwd_b_sel), e.fb);
    chk("B.stall", 32'(bus_b.stall), e.stall);
    chk("B.redirect", 32'(bus_b.redirect), e.redirect);
    chk("B.flush_if", 32'(bus_b.flush_if), e.flush);
    chk("B.busy", 32'(busy_b), e.busy);
    chk("B.err", 32'(err_b), e.err);
    chk("B.cnt_branch", 32'(cb_b), e.cb);
    chk("B.cnt_taken", 32'(ct_b), e.ct);
    chk("B.cnt_stall", 32'(cs_b), e.cs);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin e = qa.pop_front(); cmp_a(e); end
      if (qb.size() > 0) begin e = qb.pop_front(); cmp_b(e); end
    end
  end

  initial begin
    rst = 1; clr(); apply();
    ma = '{default: 0}; mb = '{default: 0};
    tick();
    step();                       // reset still held: reset-state outputs
    rst = 0;
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.cnt_branch", 32'(cb_a), 0);

    // Taken beq, no producers in flight
    clr(); set_br(CMP_BEQ, 3, 4, 1); cycle(); #1;
    chk("beq.stall", 32'(bus_a.stall), 0);
    chk("beq.redirect", 32'(bus_a.redirect), 1);
    chk("beq.flush_if", 32'(bus_a.flush_if), 0);
    tick();
    chk("beq.cnt_branch", 32'(cb_a), 1);
    chk("beq.cnt_taken", 32'(ct_a), 1);
    clr(); step();

    // ALU producer of r5 in EX: one stall, then forward from MEM
    clr(); set_br(CMP_BNE, 5, 0, 0); exw = 5; exr = 1; cycle(); #1;
    chk("alu.stall0", 32'(bus_a.stall), 1);
    tick();
    clr(); set_br(CMP_BNE, 5, 0, 0); mw = 5; mr = 1; cycle(); #1;
    chk("alu.stall1", 32'(bus_a.stall), 0);
    chk("alu.fwd_a", 32'(bus_a.fwd_a_sel), 1);
    tick();
    chk("alu.cnt_stall", 32'(cs_a), 1);
    clr(); step();

    // Load of r7 in EX: two stalls, then forward from WB
    clr(); set_br(CMP_BEQ, 1, 7, 1); exw = 7; exr = 1; exl = 1; step();
    clr(); set_br(CMP_BEQ, 1, 7, 1); mw = 7; mr = 1; ml = 1; cycle(); #1;
    chk("load.stall1", 32'(bus_a.stall), 1);
    tick();
    clr(); set_br(CMP_BEQ, 1, 7, 1); ww = 7; wr = 1; cycle(); #1;
    chk("load.fwd_b", 32'(bus_a.fwd_b_sel), 2);
    tick();
    chk("load.cnt_stall", 32'(cs_a), 3);
    clr(); step();

    // r0 is never a hazard
    clr(); set_br(CMP_BEQ, 0, 6, 1); exw = 0; exr = 1; cycle(); #1;
    chk("r0.stall", 32'(bus_a.stall), 0);
    chk("r0.fwd_a", 32'(bus_a.fwd_a_sel), 0);
    tick();
    clr(); step();

    // Different latencies on both operands: stall until the later one clears
    clr(); set_br(CMP_BNE, 4, 6, 0); exw = 4; exr = 1; exl = 1; mw = 6; mr = 1; ml = 1; step();
    clr(); set_br(CMP_BNE, 4, 6, 0); mw = 4; mr = 1; ml = 1; ww = 6; wr = 1; step();
    clr(); set_br(CMP_BNE, 4, 6, 0); ww = 4; wr = 1; step();
    clr(); step();

    // Held load producer: B (MAX_STALL=1) trips the watchdog, A does not
    for (int i = 0; i < 4; i++) begin
      clr(); set_br(CMP_BEQ, 2, 0, 1); exw = 2; exr = 1; exl = 1; step();
    end
    clr(); set_br(CMP_BEQ, 2, 0, 1); mw = 2; mr = 1; step();
    clr(); step(); step();
    chk("wd.err_b", 32'(err_b), 1);
    chk("wd.err_a", 32'(err_a), 0);
    step();
    chk("wd.sticky", 32'(err_b), 1);

    // Reset while waiting: stall drops in the reset cycle, then idle and cleared
    clr(); set_br(CMP_BEQ, 2, 0, 1); exw = 2; exr = 1; exl = 1; step(); step();
    rst = 1; cycle(); #1;
    chk("rstw.stall", 32'(bus_b.stall), 0);
    tick();
    rst = 0; clr(); cycle(); #1;
    chk("rstw.busy", 32'(busy_b), 0);
    chk("rstw.err", 32'(err_b), 0);
    tick();

    // No delay slot: taken bne pulses redirect and flush_if for one cycle
    clr(); set_br(CMP_BNE, 3, 4, 1); cycle(); #1;
    chk("ds0.flush", 32'(bus_b.flush_if), 1);
    chk("ds0.redirect", 32'(bus_b.redirect), 1);
    tick();
    clr(); cycle(); #1;
    chk("ds0.flush_next", 32'(bus_b.flush_if), 0);
    chk("ds0.redirect_next", 32'(bus_b.redirect), 0);
    tick();

    // Branch flushed out of ID while waiting: no redirect
    clr(); set_br(CMP_BNE, 9, 0, 1); exw = 9; exr = 1; step();
    clr(); cmp = 1; step();
    clr(); step();

    // Saturation of B's 4-bit counters
    for (int i = 0; i < 20; i++) begin
      clr(); set_br(CMP_BNE, 1, 2, 1); step();
      clr(); step();
    end
    chk("sat.cnt_taken", 32'(ct_b), 15);
    chk("sat.cnt_branch", 32'(cb_b), 15);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst = pct(2); iv = pct(90); ib = pct(75); op = int'($urandom_range(0, 3));
      rs = int'($urandom_range(0, 7)); rt = int'($urandom_range(0, 7));
      exw = int'($urandom_range(0, 7)); exr = pct(50); exl = pct(25);
      mw = int'($urandom_range(0, 7)); mr = pct(50); ml = pct(25);
      ww = int'($urandom_range(0, 7)); wr = pct(50); cmp = pct(50);
      step();
    end
    clr(); step();
    @(negedge clk); #1;
    chk("sb.drain", 32'(qa.size() + qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the ID stage around the branch comparator (`CMP`).
- Detects operand hazards against EX, MEM and WB, and drives the comparator's operand forwarding selects and compare opcode.
- Stalls IF/ID until both operands are valid, then issues the PC redirect and optional IF flush.
- Keeps saturating branch statistics and a stall watchdog.

Parameters:
- CNT_W, 16, width of each statistics counter (saturating).
- MAX_STALL, 4, stall-cycle limit per branch; exceeding it sets `err_watchdog`.
- DELAY_SLOT, 1: 1 = MIPS delay slot executes, no flush; 0 = flush IF on taken branch.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_is_branch  in  1  ID instruction is a conditional branch
- id_cmp_op  in  2  decoded compare opcode (header constants)
- id_rs  in  5  first compare operand register
- id_rt  in  5  second compare operand register
- ex_wa  in  5  EX destination register
- ex_regwrite  in  1  EX writes a register
- ex_is_load  in  1  EX holds a load
- mem_wa  in  5  MEM destination register
- mem_regwrite  in  1  MEM writes a register
- mem_is_load  in  1  MEM holds a load
- wb_wa  in  5  WB destination register
- wb_regwrite  in  1  WB writes a register
- cmp_out  in  1  comparator result
- cmp_op  out  2  opcode to comparator
- fwd_a_sel  out  2  CMPA source: 0 regfile, 1 MEM result, 2 WB result
- fwd_b_sel  out  2  CMPB source, same encoding as `fwd_a_sel`
- stall  out  1  freeze PC and IF/ID, bubble into EX
- redirect  out  1  one-cycle pulse: load branch target into PC
- flush_if  out  1  one-cycle pulse: squash the IF/ID instruction
- busy  out  1  FSM not in IDLE
- err_watchdog  out  1  sticky, cleared only by reset
- cnt_branch  out  CNT_W  branches resolved
- cnt_taken  out  CNT_W  branches taken
- cnt_stall  out  CNT_W  branch stall cycles

Behaviour:
- Reset: state IDLE; all counters 0; `err_watchdog` 0.
  - Combinational outputs evaluate with `id_valid` gated low during reset.
  - Result: `stall`, `redirect`, `flush_if`, `busy` = 0; `fwd_*` = 0; `cmp_op` = 0.
- Register r is "live" only if r != 0 and `id_valid & id_is_branch`.
- Operand not-ready conditions:
  - EX writes r (ALU or load).
  - MEM is a load writing r.
- Forwarding (combinational) for a ready operand:
  - MEM non-load writes r: sel = 1.
  - Else WB writes r: sel = 2.
  - Else sel = 0.
  - MEM has priority over WB.
- `ready` = both operands ready. `cmp_op` = `id_cmp_op` whenever a branch is in ID, else 0.
- FSM states: IDLE, WAIT, RESOLVED.
  - IDLE: branch in ID with `ready` → resolve combinationally this cycle, next state RESOLVED. Branch not `ready` → `stall` = 1, go to WAIT, clear stall counter.
  - WAIT: `stall` = 1, `cnt_stall` += 1 per cycle. Re-check each cycle; on `ready`, resolve and go to RESOLVED. Stall counter > MAX_STALL → set `err_watchdog`; keep stalling, no abort.
  - RESOLVED: lasts one cycle so the branch leaves ID before it can resolve again. `stall` = 0, go to IDLE. A new branch seen in this cycle is handled as from IDLE on the next cycle.
- Resolve cycle:
  - `redirect` = `cmp_out`.
  - `flush_if` = `cmp_out & ~DELAY_SLOT`.
  - `cnt_branch` += 1; `cnt_taken` += `cmp_out`.
- Latencies:
  - ALU producer in EX: exactly 1 stall, then forward from MEM.
  - Load in EX: 2 stalls, then forward from WB.
  - Load in MEM: 1 stall, then forward from WB.
- Counters saturate at all-ones and never wrap.
- `id_valid` falls while in WAIT (external flush): return to IDLE, no redirect.
- Reset mid-WAIT: IDLE next cycle, `stall` drops in the same cycle reset is sampled.
- Both operands hazardous with different latencies: stall until the later one is ready.

Decomposition:
- Shared header (`head.v`): CMP opcode constants (`CMP_beq` = 0, `CMP_bne` = 1, `CMP_blez` = 2, `CMP_bgtz` = 3), FWD_* select encodings, FSM state encodings.
- One natural sub-module, `branch_hazard_detect`: purely combinational, produces `ready` and the forwarding selects. The FSM and counters stay in the top module.

Test Plan:
- beq, rs = 3, rt = 4, no producers in flight, `cmp_out` = 1 → no stall; `redirect` = 1 same cycle; `flush_if` = 0 (DELAY_SLOT = 1); `cnt_branch` = 1, `cnt_taken` = 1.
- EX ALU writes r5, branch on rs = 5 → `stall` 1 cycle; next cycle `fwd_a_sel` = 1, resolve; `cnt_stall` = 1.
- EX load writes r7, branch on rt = 7 → 2 stall cycles; then `fwd_b_sel` = 2; `cnt_stall` = 2.
- EX writes r0, branch rs = 0 → no stall, `fwd_a_sel` = 0.
- MAX_STALL = 1, EX load on the operand, then held stall via repeated producers → `err_watchdog` = 1, sticky; reset clears it and returns FSM to IDLE, `stall` = 0.
- DELAY_SLOT = 0, taken bne → `redirect` and `flush_if` each pulse high for exactly 1 cycle. Then force `cnt_taken` near saturation: all-ones holds after further taken branches.
